// File: rtl/hs32_bus_pkg.sv
// Shared types for the HS32 memory bus arbiter: FSM encoding, requester ids
// and the request record latched per requester.
package hs32_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_F  = 2'd1,
    ST_BUSY_E  = 2'd2,
    ST_ABORT_F = 2'd3
  } state_t;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_E = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dtw;
    logic        rw;
  } req_t;

endpackage

// File: rtl/hs32_bus_req_slot.sv
// One requester slot: pend bit plus latched request record. Presents a grant
// candidate that includes a strobe arriving on the current edge.
module hs32_bus_req_slot
  import hs32_bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic stb,
  input  logic kill,
  input  logic active,
  input  logic take,
  input  req_t req,
  output logic cand,
  output req_t cand_req
);

  logic pend;
  logic accept;
  req_t held;

  // Strobes while pending or while this requester owns the bus are dropped.
  assign accept   = stb & ~pend & ~active & ~kill;
  assign cand     = (pend & ~kill) | accept;
  assign cand_req = pend ? held : req;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (kill | take) begin
      pend <= 1'b0;
    end else if (accept) begin
      pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      held <= req;
    end
  end

endmodule

// File: rtl/hs32_bus_arbiter.sv
// Memory bus arbiter between fetch (read-only) and execute (read/write).
// Execute has priority, bounded by MAX_EXEC_RUN grants while a fetch waits.
module hs32_bus_arbiter
  import hs32_bus_pkg::*;
#(
  parameter int unsigned MAX_EXEC_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] f_addr,
  input  logic        f_stb,
  output logic [31:0] f_dtr,
  output logic        f_ack,
  output logic        f_stl,
  input  logic [31:0] e_addr,
  input  logic [31:0] e_dtw,
  input  logic        e_rw,
  input  logic        e_stb,
  output logic [31:0] e_dtr,
  output logic        e_ack,
  output logic        e_stl,
  output logic [31:0] m_addr,
  output logic [31:0] m_dtw,
  output logic        m_rw,
  output logic        m_stb,
  input  logic [31:0] m_dtr,
  input  logic        m_ack,
  input  logic        m_stl
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_EXEC_RUN);

  state_t     state, state_nxt;
  logic [3:0] run;
  logic       complete, can_grant, f_active, e_active;
  logic       f_cand, e_cand, pick_f, grant_f, grant_e, gnt_id;
  req_t       f_req_in, e_req_in, f_cand_req, e_cand_req, gnt_req;

  assign f_req_in = '{addr: f_addr, dtw: 32'h0, rw: 1'b0};
  assign e_req_in = '{addr: e_addr, dtw: e_dtw, rw: e_rw};

  // A completing edge frees the requester, so its next strobe may land on it.
  assign complete  = (state != ST_IDLE) & (m_ack | m_stl);
  assign can_grant = (state == ST_IDLE) | complete;
  assign f_active  = (state == ST_BUSY_F) & ~complete;
  assign e_active  = (state == ST_BUSY_E) & ~complete;

  hs32_bus_req_slot u_slot_f (
    .clk(clk), .reset(reset), .stb(f_stb), .kill(flush), .active(f_active),
    .take(grant_f), .req(f_req_in), .cand(f_cand), .cand_req(f_cand_req)
  );

  hs32_bus_req_slot u_slot_e (
    .clk(clk), .reset(reset), .stb(e_stb), .kill(1'b0), .active(e_active),
    .take(grant_e), .req(e_req_in), .cand(e_cand), .cand_req(e_cand_req)
  );

  assign pick_f  = f_cand & (~e_cand | (run == RUN_MAX));
  assign grant_f = can_grant & pick_f;
  assign grant_e = can_grant & e_cand & ~pick_f;
  assign gnt_id  = pick_f ? REQ_F : REQ_E;
  assign gnt_req = (gnt_id == REQ_F) ? f_cand_req : e_cand_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (grant_f) begin
      state_nxt = ST_BUSY_F;
    end else if (grant_e) begin
      state_nxt = ST_BUSY_E;
    end else if (complete) begin
      state_nxt = ST_IDLE;
    end else if ((state == ST_BUSY_F) && flush) begin
      state_nxt = ST_ABORT_F;
    end
  end

  // Response path is combinational; stall wins over ack, flush mutes fetch.
  always_comb begin
    f_ack = 1'b0;
    f_stl = 1'b0;
    e_ack = 1'b0;
    e_stl = 1'b0;
    if ((state == ST_BUSY_F) && !flush) begin
      f_ack = m_ack & ~m_stl;
      f_stl = m_stl;
    end
    if (state == ST_BUSY_E) begin
      e_ack = m_ack & ~m_stl;
      e_stl = m_stl;
    end
  end

  assign f_dtr = m_dtr;
  assign e_dtr = m_dtr;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_stb  <= 1'b0;
      m_rw   <= 1'b0;
      m_addr <= 32'h0;
      m_dtw  <= 32'h0;
      run    <= 4'd0;
    end else begin
      m_stb <= grant_f | grant_e;
      if (grant_f | grant_e) begin
        m_addr <= gnt_req.addr;
        m_dtw  <= gnt_req.dtw;
        m_rw   <= gnt_req.rw;
      end
      if (grant_f || !f_cand) begin
        run <= 4'd0;
      end else if (grant_e && (run != RUN_MAX)) begin
        run <= run + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_hs32_bus_arbiter.sv
// Directed scoreboard bench for hs32_bus_arbiter: expected grants and
// responses are queued by the stimulus and popped by a negedge monitor.
module tb_hs32_bus_arbiter;
  import hs32_bus_pkg::*;

  logic        clk, reset, flush;
  logic [31:0] f_addr, f_dtr, e_addr, e_dtw, e_dtr, m_addr, m_dtw, m_dtr;
  logic        f_stb, f_ack, f_stl, e_rw, e_stb, e_ack, e_stl;
  logic        m_rw, m_stb, m_ack, m_stl;

  hs32_bus_arbiter #(.MAX_EXEC_RUN(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .f_addr(f_addr), .f_stb(f_stb), .f_dtr(f_dtr), .f_ack(f_ack), .f_stl(f_stl),
    .e_addr(e_addr), .e_dtw(e_dtw), .e_rw(e_rw), .e_stb(e_stb),
    .e_dtr(e_dtr), .e_ack(e_ack), .e_stl(e_stl),
    .m_addr(m_addr), .m_dtw(m_dtw), .m_rw(m_rw), .m_stb(m_stb),
    .m_dtr(m_dtr), .m_ack(m_ack), .m_stl(m_stl)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dtw;
    logic        rw;
  } grant_t;

  typedef struct {
    logic [3:0]  kind;
    logic [31:0] data;
  } resp_t;

  localparam logic [3:0] K_FACK = 4'b0001;
  localparam logic [3:0] K_FSTL = 4'b0010;
  localparam logic [3:0] K_EACK = 4'b0100;
  localparam logic [3:0] K_ESTL = 4'b1000;

  grant_t gq[$];
  resp_t  rq[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic grant_t mk_g(logic [31:0] a, logic [31:0] d, logic rw);
    grant_t g;
    g.addr = a;
    g.dtw  = d;
    g.rw   = rw;
    return g;
  endfunction

  function automatic resp_t mk_r(logic [3:0] k, logic [31:0] d);
    resp_t r;
    r.kind = k;
    r.data = d;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every m_stb and every requester response is matched in order.
  grant_t      mg;
  resp_t       mr;
  logic [3:0]  obs;
  logic [31:0] obs_data;
  always @(negedge clk) begin
    if (m_stb === 1'b1) begin
      n_cmp++;
      if (gq.size() == 0) begin
        n_bad++;
        $display("FAIL grant_unexpected: got addr=%h rw=%b, expected no grant", m_addr, m_rw);
      end else begin
        mg = gq.pop_front();
        if (m_addr !== mg.addr || m_dtw !== mg.dtw || m_rw !== mg.rw) begin
          n_bad++;
          $display("FAIL grant: got addr=%h dtw=%h rw=%b, expected addr=%h dtw=%h rw=%b",
                   m_addr, m_dtw, m_rw, mg.addr, mg.dtw, mg.rw);
        end
      end
    end
    obs      = {e_stl, e_ack, f_stl, f_ack};
    obs_data = (obs[3] | obs[2]) ? e_dtr : f_dtr;
    if (obs !== 4'b0000) begin
      n_cmp++;
      if (rq.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected: got {e_stl,e_ack,f_stl,f_ack}=%b, expected none", obs);
      end else begin
        mr = rq.pop_front();
        if (obs !== mr.kind || obs_data !== mr.data) begin
          n_bad++;
          $display("FAIL resp: got kind=%b data=%h, expected kind=%b data=%h",
                   obs, obs_data, mr.kind, mr.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0;
    f_addr = 32'h0; f_stb = 1'b0;
    e_addr = 32'h0; e_dtw = 32'h0; e_rw = 1'b0; e_stb = 1'b0;
    m_dtr = 32'h0; m_ack = 1'b0; m_stl = 1'b0;
    repeat (2) cyc();
    chk("rst_m_stb", 32'(m_stb), 32'h0);
    chk("rst_m_rw", 32'(m_rw), 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_dtw", m_dtw, 32'h0);
    chk("rst_resp", 32'({e_stl, e_ack, f_stl, f_ack}), 32'h0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    reset = 1'b0;
    cyc();

    // 1: single fetch, ack two cycles after m_stb
    f_addr = 32'h100; f_stb = 1'b1;
    gq.push_back(mk_g(32'h100, 32'h0, 1'b0));
    chk("t1_no_early_stb", 32'(m_stb), 32'h0);
    cyc(); f_stb = 1'b0;
    chk("t1_stb_latency", 32'(m_stb), 32'h1);
    cyc(); cyc();
    m_ack = 1'b1; m_dtr = 32'hDEADBEEF;
    rq.push_back(mk_r(K_FACK, 32'hDEADBEEF));
    cyc(); m_ack = 1'b0;

    // 2: simultaneous strobes, execute first, fetch granted on the E-ack edge
    f_addr = 32'h100; f_stb = 1'b1;
    e_addr = 32'h2000; e_dtw = 32'h55; e_rw = 1'b1; e_stb = 1'b1;
    gq.push_back(mk_g(32'h2000, 32'h55, 1'b1));
    gq.push_back(mk_g(32'h100, 32'h0, 1'b0));
    cyc(); f_stb = 1'b0; e_stb = 1'b0; e_rw = 1'b0;
    cyc();
    m_ack = 1'b1; m_dtr = 32'h11;
    rq.push_back(mk_r(K_EACK, 32'h11));
    cyc(); m_ack = 1'b0;
    chk("t2_f_backtoback", 32'(m_stb), 32'h1);
    cyc();
    m_ack = 1'b1; m_dtr = 32'h22;
    rq.push_back(mk_r(K_FACK, 32'h22));
    cyc(); m_ack = 1'b0;

    // 3: fetch stays pending under continuous execute traffic
    f_addr = 32'h400; f_stb = 1'b1;
    e_addr = 32'h3000; e_dtw = 32'h0; e_stb = 1'b1;
    gq.push_back(mk_g(32'h3000, 32'h0, 1'b0));
    cyc(); f_stb = 1'b0; e_stb = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      m_ack = 1'b1; m_dtr = 32'hA000 + 32'(i);
      rq.push_back(mk_r(K_EACK, 32'hA000 + 32'(i)));
      e_addr = 32'h3000 + 32'(4 * i); e_stb = 1'b1;
      if (i == 4) gq.push_back(mk_g(32'h400, 32'h0, 1'b0));
      else        gq.push_back(mk_g(32'h3000 + 32'(4 * i), 32'h0, 1'b0));
      cyc(); m_ack = 1'b0; e_stb = 1'b0;
    end
    cyc();
    m_ack = 1'b1; m_dtr = 32'hB000;
    rq.push_back(mk_r(K_FACK, 32'hB000));
    gq.push_back(mk_g(32'h3010, 32'h0, 1'b0));
    cyc(); m_ack = 1'b0;
    cyc();
    m_ack = 1'b1; m_dtr = 32'hB001;
    rq.push_back(mk_r(K_EACK, 32'hB001));
    cyc(); m_ack = 1'b0;

    // 4: flush while fetch is in flight; the late ack is swallowed
    f_addr = 32'h500; f_stb = 1'b1;
    gq.push_back(mk_g(32'h500, 32'h0, 1'b0));
    cyc(); f_stb = 1'b0;
    flush = 1'b1;
    cyc(); flush = 1'b0;
    chk("t4_abort_state", 32'(dut.state), 32'(ST_ABORT_F));
    cyc(); cyc();
    m_ack = 1'b1; m_dtr = 32'hBAD0BAD0;
    #1;
    chk("t4_f_ack_muted", 32'(f_ack), 32'h0);
    cyc(); m_ack = 1'b0;
    chk("t4_idle_after_ack", 32'(dut.state), 32'(ST_IDLE));
    f_addr = 32'h600; f_stb = 1'b1;
    gq.push_back(mk_g(32'h600, 32'h0, 1'b0));
    cyc(); f_stb = 1'b0;
    cyc();
    m_ack = 1'b1; m_dtr = 32'h600D;
    rq.push_back(mk_r(K_FACK, 32'h600D));
    cyc(); m_ack = 1'b0;

    // 5: execute stalled, retried; then ack+stl together, then stray ack in IDLE
    e_addr = 32'h700; e_dtw = 32'h0; e_rw = 1'b0; e_stb = 1'b1;
    gq.push_back(mk_g(32'h700, 32'h0, 1'b0));
    cyc(); e_stb = 1'b0;
    cyc();
    m_stl = 1'b1; m_dtr = 32'h77;
    rq.push_back(mk_r(K_ESTL, 32'h77));
    cyc(); m_stl = 1'b0;
    chk("t5_idle_after_stl", 32'(dut.state), 32'(ST_IDLE));
    e_stb = 1'b1;
    gq.push_back(mk_g(32'h700, 32'h0, 1'b0));
    cyc(); e_stb = 1'b0;
    cyc();
    m_ack = 1'b1; m_dtr = 32'h78;
    rq.push_back(mk_r(K_EACK, 32'h78));
    cyc(); m_ack = 1'b0;
    e_addr = 32'h900; e_stb = 1'b1;
    gq.push_back(mk_g(32'h900, 32'h0, 1'b0));
    cyc(); e_stb = 1'b0;
    m_ack = 1'b1; m_stl = 1'b1; m_dtr = 32'h99;
    rq.push_back(mk_r(K_ESTL, 32'h99));
    cyc(); m_ack = 1'b0; m_stl = 1'b0;
    m_ack = 1'b1;
    #1;
    chk("t5_idle_ack_ignored", 32'({e_stl, e_ack, f_stl, f_ack}), 32'h0);
    cyc(); m_ack = 1'b0;

    // 6: reset in BUSY_E, then a late ack
    e_addr = 32'h800; e_dtw = 32'hAA; e_rw = 1'b1; e_stb = 1'b1;
    gq.push_back(mk_g(32'h800, 32'hAA, 1'b1));
    cyc(); e_stb = 1'b0; e_rw = 1'b0;
    reset = 1'b1;
    cyc(); reset = 1'b0;
    chk("t6_m_stb", 32'(m_stb), 32'h0);
    chk("t6_m_rw", 32'(m_rw), 32'h0);
    chk("t6_m_addr", m_addr, 32'h0);
    chk("t6_m_dtw", m_dtw, 32'h0);
    chk("t6_state", 32'(dut.state), 32'(ST_IDLE));
    m_ack = 1'b1; m_dtr = 32'h66;
    #1;
    chk("t6_no_e_ack", 32'({e_stl, e_ack, f_stl, f_ack}), 32'h0);
    cyc(); m_ack = 1'b0;

    repeat (3) cyc();
    chk("grants_drained", 32'(gq.size()), 32'h0);
    chk("resps_drained", 32'(rq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
